cache_request_sequencer: RTL and testbench

Request front-end that sits directly upstream of `cache_and_ram`. Accepts CPU read/write requests through a valid/ready handshake and buffers them in a small FIFO. Presents each request to the cache's unhandshaked `address`/`data`/`mode` inputs for a fixed number of cycles. For reads, captures the cache's `out` word and returns it as a one-cycle response.

---
 rtl/cache_request_sequencer_if.sv | 30 +++
 rtl/cache_request_sequencer.sv | 156 +++++++++++++++
 tb/tb_cache_request_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_request_sequencer_if.sv
// Request/cache/response bundle for cache_request_sequencer.
// The slave side is the sequencer; the master side is whoever issues
// requests and also plays the cache (drives cache_out).
interface cache_request_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic [31:0] cache_address;
    logic [31:0] cache_data;
    logic        cache_mode;
    logic [31:0] cache_out;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] resp_address;
    logic        busy;

    modport slave (
        input  req_valid, req_mode, req_address, req_data, cache_out,
        output req_ready, cache_address, cache_data, cache_mode,
               resp_valid, resp_data, resp_address, busy
    );

    modport master (
        output req_valid, req_mode, req_address, req_data, cache_out,
        input  req_ready, cache_address, cache_data, cache_mode,
               resp_valid, resp_data, resp_address, busy
    );
endinterface

// File: rtl/cache_request_sequencer.sv
// Buffers CPU requests in a small FIFO and presents each one to the
// unhandshaked cache inputs for HOLD_CYCLES cycles. Reads return the
// cache word as a one-cycle response when the hold window closes.
module cache_request_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    cache_request_sequencer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state_q, state_d;
    req_t [DEPTH-1:0]    mem_q, mem_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [31:0]         cache_address_q, cache_address_d;
    logic [31:0]         cache_data_q, cache_data_d;
    logic                cache_mode_q, cache_mode_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [31:0]         resp_address_q, resp_address_d;
    logic                busy_q, busy_d;

    logic req_ready;
    logic push;
    logic pop;
    req_t head;

    // Ready comes only from registered occupancy, so a full FIFO ignores
    // req_valid even on an edge that pops. Pop uses pre-edge count, so a
    // freshly pushed entry can never bypass to the cache on the same edge.
    assign req_ready = (count_q < DEPTH_C);
    assign push      = bus.req_valid && req_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // FIFO storage and pointer/occupancy next-state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{mode: bus.req_mode, addr: bus.req_address, data: bus.req_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Sequencer FSM: load a request, hold it, then drop mode and answer reads
    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        cache_address_d = cache_address_q;
        cache_data_d    = cache_data_q;
        cache_mode_d    = cache_mode_q;
        resp_valid_d    = 1'b0;
        resp_data_d     = resp_data_q;
        resp_address_d  = resp_address_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    cache_address_d = head.addr;
                    cache_data_d    = head.data;
                    cache_mode_d    = head.mode;
                    hold_cnt_d      = HOLD_LOAD;
                    state_d         = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end else begin
                    state_d      = IDLE;
                    // Mode drops so the cache is never rewritten while idle.
                    cache_mode_d = 1'b0;
                    if (!cache_mode_q) begin
                        resp_valid_d   = 1'b1;
                        resp_data_d    = bus.cache_out;
                        resp_address_d = cache_address_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == HOLD) || (count_d != '0);
    end

    // Control and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            hold_cnt_q      <= '0;
            cache_address_q <= '0;
            cache_data_q    <= '0;
            cache_mode_q    <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_address_q  <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            hold_cnt_q      <= hold_cnt_d;
            cache_address_q <= cache_address_d;
            cache_data_q    <= cache_data_d;
            cache_mode_q    <= cache_mode_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_address_q  <= resp_address_d;
            busy_q          <= busy_d;
        end
    end

    // Entry storage needs no reset: occupancy gates every read of it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.req_ready     = req_ready;
    assign bus.cache_address = cache_address_q;
    assign bus.cache_data    = cache_data_q;
    assign bus.cache_mode    = cache_mode_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_address  = resp_address_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_cache_request_sequencer.sv
// Bench for cache_request_sequencer: a word RAM stands in for the cache,
// and a queue-based reference model predicts every output cycle by cycle.
module tb_cache_request_sequencer;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_request_sequencer_if bus();

    cache_request_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Cache stand-in: modulo-4096 word RAM, written every edge mode is high
    logic [31:0] ram [4096];
    assign bus.cache_out = ram[bus.cache_address[11:0]];
    always @(posedge clk) if (bus.cache_mode) ram[bus.cache_address[11:0]] <= bus.cache_data;

    typedef struct {
        bit          mode;
        logic [31:0] addr;
        logic [31:0] data;
    } rq_t;

    // Reference model: pending queue, one active request with a countdown
    rq_t         m_q[$];
    bit          m_active, m_cmode, m_rv, m_busy, m_acc, m_pop;
    int          m_rem;
    logic [31:0] m_caddr, m_cdata, m_rd, m_ra;
    logic [31:0] m_mem [4096];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic void model_edge(input bit r, input bit v, input rq_t x);
        rq_t h;
        if (r) begin
            m_q.delete();
            m_active = 0; m_rem = 0; m_cmode = 0; m_caddr = 0; m_cdata = 0;
            m_rv = 0; m_rd = 0; m_ra = 0; m_busy = 0; m_acc = 0; m_pop = 0;
            return;
        end
        m_acc = v && (m_q.size() < DEPTH);
        m_pop = 0;
        m_rv  = 0;
        if (m_active) begin
            m_rem--;
            if (m_rem == 0) begin
                m_active = 0;
                if (!m_cmode) begin
                    m_rv = 1; m_rd = m_mem[m_caddr[11:0]]; m_ra = m_caddr;
                end
                m_cmode = 0;
            end
        end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_pop = 1; m_active = 1; m_rem = HOLD;
            m_caddr = h.addr; m_cdata = h.data; m_cmode = h.mode;
            if (h.mode) m_mem[h.addr[11:0]] = h.data;
        end
        if (m_acc) m_q.push_back(x);
        m_busy = m_active || (m_q.size() > 0);
    endfunction

    task automatic tick(input bit r, input bit v, input bit md, input logic [31:0] a, input logic [31:0] d);
        rq_t x;
        x.mode = md; x.addr = a; x.data = d;
        rst = r; bus.req_valid = v; bus.req_mode = md; bus.req_address = a; bus.req_data = d;
        @(posedge clk);
        model_edge(r, v, x);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        tick(1, 0, 0, 32'h0, 32'h0);
        tick(1, 0, 0, 32'h0, 32'h0);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.cache_address !== 32'h0) begin failures++; $display("FAIL reset_cache_address got=%h exp=0", bus.cache_address); end
        checks++; if (bus.cache_data !== 32'h0) begin failures++; $display("FAIL reset_cache_data got=%h exp=0", bus.cache_data); end
        checks++; if (bus.cache_mode !== 1'b0) begin failures++; $display("FAIL reset_cache_mode got=%b exp=0", bus.cache_mode); end
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data); end
        checks++; if (bus.resp_address !== 32'h0) begin failures++; $display("FAIL reset_resp_address got=%h exp=0", bus.resp_address); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_single_write;
        int rv_seen = 0;
        tick(0, 1, 1, 32'hA7E5FBDC, 32'h00080855);            // edge E
        for (int k = 1; k <= 8; k++) begin
            idle(1);                                          // edge E+k
            if (bus.resp_valid) rv_seen++;
            if (k <= 4) begin
                checks++; if (bus.cache_mode !== 1'b1 || bus.cache_address !== 32'hA7E5FBDC) begin
                    failures++; $display("FAIL wr_hold k=%0d got mode=%b addr=%h exp mode=1 addr=a7e5fbdc", k, bus.cache_mode, bus.cache_address);
                end
            end else if (k == 5) begin
                checks++; if (bus.cache_mode !== 1'b0 || bus.cache_address !== 32'hA7E5FBDC) begin
                    failures++; $display("FAIL wr_exit got mode=%b addr=%h exp mode=0 addr=a7e5fbdc", bus.cache_mode, bus.cache_address);
                end
            end
        end
        checks++; if (rv_seen != 0) begin failures++; $display("FAIL wr_no_resp got=%0d pulses exp=0", rv_seen); end
    endtask

    task automatic test_write_read;
        int pulses = 0;
        int at = -1;
        logic [31:0] rd = 0, ra = 0;
        tick(0, 1, 1, 32'h000F47D1, 32'h018B1B16);            // edge E
        tick(0, 1, 0, 32'h000F47D1, 32'h0);                   // edge E+1
        for (int k = 2; k <= 16; k++) begin
            idle(1);
            if (k == 5) begin
                checks++; if (bus.cache_mode !== 1'b0) begin failures++; $display("FAIL wrrd_gap got mode=%b exp=0", bus.cache_mode); end
            end
            if (bus.resp_valid) begin pulses++; at = k; rd = bus.resp_data; ra = bus.resp_address; end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL wrrd_pulses got=%0d exp=1", pulses); end
        checks++; if (at != 10) begin failures++; $display("FAIL wrrd_resp_cycle got=%0d exp=10", at); end
        checks++; if (rd !== 32'h018B1B16) begin failures++; $display("FAIL wrrd_resp_data got=%h exp=018b1b16", rd); end
        checks++; if (ra !== 32'h000F47D1) begin failures++; $display("FAIL wrrd_resp_address got=%h exp=000f47d1", ra); end
    endtask

    task automatic test_full;
        logic [31:0] order [6];
        int idx = 0, issued = 0, saw_full = 0, acc5 = -1, k = 0;
        for (int i = 0; i < 6; i++) order[i] = 32'h0000_1000 * (i + 1) + 32'(i);
        tick(0, 1, 1, order[0], 32'hD0);                      // edge E, popped at E+1
        if (m_pop) issued++;
        idle(1);
        if (m_pop) begin
            checks++; if (bus.cache_address !== order[0]) begin failures++; $display("FAIL full_order0 got=%h exp=%h", bus.cache_address, order[0]); end
            issued++;
        end
        while (issued < 6 && k < 60) begin
            k++;
            if (idx < 5) tick(0, 1, 1, order[idx + 1], 32'hD0 + 32'(idx + 1));
            else idle(1);
            if (m_acc && idx < 5) begin idx++; if (idx == 5) acc5 = k; end
            if (!bus.req_ready) saw_full++;
            checks++; if (bus.req_ready !== (m_q.size() < DEPTH)) begin failures++; $display("FAIL full_ready k=%0d got=%b", k, bus.req_ready); end
            if (m_pop) begin
                checks++; if (bus.cache_address !== order[issued]) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", issued, bus.cache_address, order[issued]); end
                issued++;
            end
        end
        bus.req_valid = 0;
        checks++; if (issued != 6) begin failures++; $display("FAIL full_issued got=%0d exp=6", issued); end
        checks++; if (saw_full == 0) begin failures++; $display("FAIL full_ready_low got=%0d cycles exp>0", saw_full); end
        checks++; if (acc5 != 6) begin failures++; $display("FAIL full_fifth_accept got=%0d exp=6", acc5); end
        idle(6);
    endtask

    task automatic test_simul;
        logic [31:0] a = 32'h0000_0123, b = 32'h0000_0456;
        tick(0, 1, 0, a, 32'h0);                              // edge E, count 1
        tick(0, 1, 0, b, 32'h0);                              // edge E+1, pop + push
        checks++; if (bus.cache_address !== a || bus.req_ready !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL simul_first got addr=%h rdy=%b busy=%b exp addr=%h rdy=1 busy=1", bus.cache_address, bus.req_ready, bus.busy, a);
        end
        idle(4);                                              // E+5: first read answered
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_address !== a) begin
            failures++; $display("FAIL simul_resp_a got v=%b addr=%h exp v=1 addr=%h", bus.resp_valid, bus.resp_address, a);
        end
        idle(1);                                              // E+6: second popped
        checks++; if (bus.cache_address !== b) begin failures++; $display("FAIL simul_second got=%h exp=%h", bus.cache_address, b); end
        idle(4);                                              // E+10
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_address !== b) begin
            failures++; $display("FAIL simul_resp_b got v=%b addr=%h exp v=1 addr=%h", bus.resp_valid, bus.resp_address, b);
        end
        idle(3);
    endtask

    task automatic test_alias;
        int seen = 0;
        logic [31:0] rd = 0;
        tick(0, 1, 1, 32'hA7E5FBDC, 32'h000038C0);
        tick(0, 1, 0, 32'hA7E5FBDC, 32'h0);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (bus.resp_valid) begin seen++; rd = bus.resp_data; end
        end
        checks++; if (seen != 1 || rd !== 32'h000038C0) begin failures++; $display("FAIL alias got pulses=%0d data=%h exp 1 000038c0", seen, rd); end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        tick(0, 1, 1, 32'h0000_0777, 32'h1234_5678);          // E
        tick(0, 1, 0, 32'h0000_0777, 32'h0);                  // E+1 pop write
        idle(1);                                              // E+2 in HOLD
        tick(1, 0, 0, 32'h0, 32'h0);                          // reset edge
        checks++; if (bus.cache_mode !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid got mode=%b busy=%b rdy=%b rv=%b exp 0 0 1 0", bus.cache_mode, bus.busy, bus.req_ready, bus.resp_valid);
        end
        for (int k = 0; k < 12; k++) begin
            idle(1);
            if (bus.resp_valid || bus.cache_mode) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d active cycles exp=0", bad); end
    endtask

    task automatic test_random;
        bit v, md;
        logic [31:0] a, d;
        for (int k = 0; k < 500; k++) begin
            v  = ($urandom_range(0, 9) < 6);
            md = $urandom_range(0, 1);
            a  = 32'(($urandom_range(0, 3) << 12) | $urandom_range(0, 7));
            d  = $urandom;
            tick(0, v, md, a, d);
            checks++; if (bus.req_ready !== (m_q.size() < DEPTH) || bus.busy !== m_busy
                          || bus.cache_mode !== m_cmode || bus.cache_address !== m_caddr || bus.cache_data !== m_cdata) begin
                failures++; $display("FAIL rand_ctl k=%0d got rdy=%b busy=%b mode=%b addr=%h data=%h exp %b %b %b %h %h",
                    k, bus.req_ready, bus.busy, bus.cache_mode, bus.cache_address, bus.cache_data,
                    (m_q.size() < DEPTH), m_busy, m_cmode, m_caddr, m_cdata);
            end
            checks++; if (bus.resp_valid !== m_rv || bus.resp_data !== m_rd || bus.resp_address !== m_ra) begin
                failures++; $display("FAIL rand_resp k=%0d got v=%b data=%h addr=%h exp %b %h %h",
                    k, bus.resp_valid, bus.resp_data, bus.resp_address, m_rv, m_rd, m_ra);
            end
        end
        bus.req_valid = 0;
        idle(30);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin ram[i] = 32'h0; m_mem[i] = 32'h0; end
        bus.req_valid = 0; bus.req_mode = 0; bus.req_address = 0; bus.req_data = 0;
        test_reset();
        test_single_write();
        test_write_read();
        test_full();
        test_simul();
        test_alias();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
